sfp_seq: RTL and testbench

- Sequencer that drives the sfp accumulate/ReLU unit from the producer side.
- Accepts a valid/ready stream of bw-bit partial sums and issues one sfp_acc per accepted word for a programmed count.
- Optionally fires one sfp_relu cycle, captures the sfp result and returns it on a valid/ready result port.
- Sits between the psum source (array/ofifo) and the sfp; one instance per sfp column.

---
 rtl/sfp_seq_if.sv | 33 +++
 rtl/sfp_seq.sv | 112 +++++++++++
 tb/tb_sfp_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sfp_seq_if.sv
// rtl/sfp_seq_if.sv - control, psum stream, sfp and result signals of one sfp_seq column
interface sfp_seq_if #(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
);
  logic                start;
  logic [len_bw-1:0]   cfg_len;
  logic                cfg_relu;
  logic                busy;
  logic [bw-1:0]       din;
  logic                din_valid;
  logic                din_ready;
  logic [bw-1:0]       sfp_in;
  logic                sfp_acc;
  logic                sfp_relu;
  logic                sfp_clr;
  logic [psum_bw-1:0]  sfp_out;
  logic [psum_bw-1:0]  res;
  logic                res_valid;
  logic                res_ready;
  logic [15:0]         stall_cnt;

  modport slave (
    input  start, cfg_len, cfg_relu, din, din_valid, sfp_out, res_ready,
    output busy, din_ready, sfp_in, sfp_acc, sfp_relu, sfp_clr, res, res_valid, stall_cnt
  );

  modport master (
    output start, cfg_len, cfg_relu, din, din_valid, sfp_out, res_ready,
    input  busy, din_ready, sfp_in, sfp_acc, sfp_relu, sfp_clr, res, res_valid, stall_cnt
  );
endinterface

// File: rtl/sfp_seq.sv
// rtl/sfp_seq.sv - producer-side sequencer for the sfp accumulate/ReLU unit
// Optional stall counter: define SFP_SEQ_STALL_CNT_EN.
module sfp_seq #(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic     clk,
  input  logic     reset,
  sfp_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLR, ACC, RELU, CAP, OUT} state_t;

  state_t              state_q, state_d;
  logic [len_bw-1:0]   cnt_q, cnt_d;
  logic                relu_q, relu_d;
  logic [psum_bw-1:0]  res_q, res_d;

  logic busy, din_ready, sfp_acc, sfp_relu, sfp_clr, res_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      relu_q  <= relu_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    relu_d  = relu_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.cfg_len;
          relu_d  = bus.cfg_relu;
          state_d = CLR;
        end
      end
      CLR: begin
        if (cnt_q != '0)  state_d = ACC;
        else if (relu_q)  state_d = RELU;
        else              state_d = CAP;
      end
      ACC: begin
        if (bus.din_valid) begin
          cnt_d = cnt_q - len_bw'(1);
          if (cnt_q == len_bw'(1)) state_d = relu_q ? RELU : CAP;
        end
      end
      RELU: state_d = CAP;
      CAP: begin
        // sfp_out already reflects the final acc/relu edge here
        res_d   = bus.sfp_out;
        state_d = OUT;
      end
      OUT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    din_ready = (state_q == ACC);
    sfp_acc   = (state_q == ACC) && bus.din_valid;
    sfp_relu  = (state_q == RELU);
    // the sfp is also held clear for the whole of our own reset
    sfp_clr   = !reset || (state_q == CLR);
    res_valid = (state_q == OUT);
  end

  assign bus.busy      = busy;
  assign bus.din_ready = din_ready;
  assign bus.sfp_in    = bus.din;
  assign bus.sfp_acc   = sfp_acc;
  assign bus.sfp_relu  = sfp_relu;
  assign bus.sfp_clr   = sfp_clr;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid;

`ifdef SFP_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  always_comb begin
    stall_evt = ((state_q == ACC) && !bus.din_valid) ||
                ((state_q == OUT) && !bus.res_ready);
    stall_d   = stall_q;
    if ((state_q == IDLE) && bus.start)      stall_d = '0;
    else if (stall_evt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_sfp_seq.sv
// tb/tb_sfp_seq.sv - self-checking bench for sfp_seq with a behavioural sfp (thres=0)
module tb_sfp_seq;
  localparam int BW = 8;
  localparam int PB = 16;
  localparam int LB = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   acc_pulses, relu_pulses, overlap, dr_cycles;
  int   total, fails;
  int   words[$];
  int   gaps[$];
  int   rdelay;

  sfp_seq_if #(.bw(BW), .psum_bw(PB), .len_bw(LB)) bus ();

  sfp_seq #(.bw(BW), .psum_bw(PB), .len_bw(LB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural sfp: sign-extended accumulate with wrap, ReLU against threshold 0
  logic signed [PB-1:0] sfp_q;
  logic signed [BW-1:0] sfp_in_s;
  assign sfp_in_s    = bus.sfp_in;
  assign bus.sfp_out = sfp_q;
  always @(posedge clk or posedge bus.sfp_clr) begin
    if (bus.sfp_clr)        sfp_q <= '0;
    else if (bus.sfp_acc)   sfp_q <= sfp_q + {{(PB-BW){sfp_in_s[BW-1]}}, sfp_in_s};
    else if (bus.sfp_relu && sfp_q < 0) sfp_q <= '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sfp_acc)                 acc_pulses  <= acc_pulses + 1;
    if (bus.sfp_relu)                relu_pulses <= relu_pulses + 1;
    if (bus.sfp_acc && bus.sfp_relu) overlap     <= overlap + 1;
    if (bus.din_ready)               dr_cycles   <= dr_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int len, input bit relu, input bit poke);
    int sum, stalls, gapsum, bound, t0, w, acc0, relu0, dr0;
    bit nogap;
    logic signed [PB-1:0] s16;
    logic [PB-1:0] expv;
    sum = 0; stalls = 0; gapsum = 0; nogap = 1;
    foreach (words[i]) sum += words[i];
    foreach (gaps[i]) gapsum += gaps[i];
    s16 = PB'(sum);
    if (relu && s16 < 0) s16 = '0;
    expv = s16;
    acc0 = acc_pulses; relu0 = relu_pulses; dr0 = dr_cycles;

    @(negedge clk);
    bus.start = 1'b1; bus.cfg_len = len[LB-1:0]; bus.cfg_relu = relu; t0 = cyc;
    @(negedge clk);
    if (!poke) bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);

    for (int i = 0; i < len; i++) begin
      bound = 0;
      while (!bus.din_ready && bound < 100) begin
        bus.din_valid = 1'b0;
        @(negedge clk);
        bound++;
      end
      chk("din_ready_seen", bus.din_ready, 1);
      bus.din_valid = 1'b0;
      repeat (gaps[i]) begin @(negedge clk); stalls++; end
      if (gaps[i] != 0) nogap = 0;
      w = words[i];
      bus.din = w[BW-1:0];
      bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;

    bound = 0;
    while (!bus.res_valid && bound < 2000) begin @(negedge clk); bound++; end
    chk("res_valid", bus.res_valid, 1);
    if (nogap) chk("latency", cyc - t0, 1 + len + int'(relu) + 1 + 1);
    chk("res", bus.res, expv);
    repeat (rdelay) begin
      @(negedge clk);
      stalls++;
      chk("res_hold", bus.res, expv);
      chk("res_valid_hold", bus.res_valid, 1);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    chk("res_valid_fall", bus.res_valid, 0);
    chk("busy_idle", bus.busy, 0);
    chk("acc_pulses", acc_pulses - acc0, len);
    chk("relu_pulses", relu_pulses - relu0, int'(relu));
    chk("din_ready_cycles", dr_cycles - dr0, len + gapsum);
`ifdef SFP_SEQ_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, stalls);
`else
    chk("stall_cnt_tied", bus.stall_cnt, 0);
`endif
    if (poke) begin
      @(negedge clk);
      chk("start_ignored", bus.busy, 0);
    end
  endtask

  task automatic plain(input int n);
    gaps = {};
    for (int i = 0; i < n; i++) gaps.push_back(0);
  endtask

  initial begin
    cyc = 0; acc_pulses = 0; relu_pulses = 0; overlap = 0; dr_cycles = 0;
    total = 0; fails = 0; rdelay = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_relu = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_din_ready", bus.din_ready, 0);
    chk("rst_sfp_acc", bus.sfp_acc, 0);
    chk("rst_sfp_relu", bus.sfp_relu, 0);
    chk("rst_sfp_clr", bus.sfp_clr, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sfp_clr", bus.sfp_clr, 0);

    words = '{5, -2, 7};  plain(3); rdelay = 0; run_job(3, 1'b0, 1'b0);
    words = '{-3, -1};    plain(2); rdelay = 0; run_job(2, 1'b1, 1'b0);
    words = '{4, 4};      plain(2); rdelay = 0; run_job(2, 1'b0, 1'b0);
    words = '{1, 2, 3, 4}; gaps = '{0, 0, 2, 0}; rdelay = 3; run_job(4, 1'b0, 1'b0);
    words = {};           plain(0); rdelay = 1; run_job(0, 1'b1, 1'b1);

    // asynchronous reset after two of four words
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_len = 8'd4; bus.cfg_relu = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.din = 8'd6; bus.din_valid = bus.din_ready;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_din_ready", bus.din_ready, 0);
    chk("mid_rst_sfp_clr", bus.sfp_clr, 1);
    chk("mid_rst_sfp_out", bus.sfp_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    words = '{9}; plain(1); rdelay = 0; run_job(1, 1'b0, 1'b0);

    words = {}; for (int i = 0; i < 255; i++) words.push_back(127);
    plain(255); rdelay = 0; run_job(255, 1'b0, 1'b0);
    words = {}; for (int i = 0; i < 255; i++) words.push_back(-128);
    plain(255); rdelay = 0; run_job(255, 1'b0, 1'b0);

    for (int j = 0; j < 10; j++) begin
      int n;
      bit r;
      n = $urandom_range(0, 6);
      r = 1'($urandom_range(0, 1));
      words = {}; gaps = {};
      for (int i = 0; i < n; i++) begin
        words.push_back(int'($urandom_range(0, 255)) - 128);
        gaps.push_back($urandom_range(0, 2));
      end
      rdelay = $urandom_range(0, 3);
      run_job(n, r, 1'($urandom_range(0, 1)));
    end

    chk("acc_relu_overlap", overlap, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
